// File: rtl/gpio_seq_pkg.sv
// Shared constants for the GPIO pattern sequencer: FSM encoding, pattern modes
// and AXI-lite values.
package gpio_seq_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;
   localparam logic [1:0] ST_WAIT  = 2'd3;

   localparam logic [1:0] MODE_CNT    = 2'b00;
   localparam logic [1:0] MODE_WALK   = 2'b01;
   localparam logic [1:0] MODE_TOGGLE = 2'b10;
   localparam logic [1:0] MODE_HOLD   = 2'b11;

   localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
   localparam logic [11:0] GPIO_REG_OFFSET = 12'h000;

endpackage

// File: rtl/gpio_seq_next_pattern.sv
// Combinational next-pattern generator: counter, walking-one, toggle or hold.
module gpio_seq_next_pattern
   import gpio_seq_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [W-1:0] cur,
   input  logic [1:0]   mode,
   output logic [W-1:0] nxt
);

   always_comb begin
      nxt = cur;
      case (mode)
         MODE_CNT:    nxt = cur + W'(1);
         // an all-zero pattern would rotate forever as zero, so it restarts the walk
         MODE_WALK:   nxt = (cur == '0) ? W'(1) : {cur[W-2:0], cur[W-1]};
         MODE_TOGGLE: nxt = ~cur;
         default:     nxt = cur;
      endcase
   end

endmodule

// File: rtl/gpio_pattern_sequencer.sv
// AXI-lite write-only master that periodically writes a generated pattern to
// the GPIO output register, one outstanding write at a time.
module gpio_pattern_sequencer
   import gpio_seq_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] GPIO_ADDR = ADDR_WIDTH'(GPIO_REG_OFFSET),
   parameter int CNT_WIDTH = 24
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    enable,
   input  logic [1:0]              mode,
   input  logic [DATA_WIDTH-1:0]   seed,
   input  logic [CNT_WIDTH-1:0]    interval,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   output logic [DATA_WIDTH-1:0]   pattern_out,
   output logic [15:0]             write_count,
   output logic                    err
);

   logic [1:0]            state;
   logic [DATA_WIDTH-1:0] cur, nxt, pat;
   logic [CNT_WIDTH-1:0]  cnt;
   logic [15:0]           wcnt;
   logic                  aw_vld, w_vld, b_rdy, err_r;

   gpio_seq_next_pattern #(.W(DATA_WIDTH)) u_next (
      .cur  (cur),
      .mode (mode),
      .nxt  (nxt)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state  <= ST_IDLE;
         aw_vld <= 1'b0;
         w_vld  <= 1'b0;
         b_rdy  <= 1'b0;
         cur    <= '0;
         pat    <= '0;
         wcnt   <= '0;
         err_r  <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (enable) begin
                  cur    <= seed;
                  err_r  <= 1'b0;
                  wcnt   <= '0;
                  aw_vld <= 1'b1;
                  w_vld  <= 1'b1;
                  state  <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // each channel retires on its own handshake; enable is ignored here
               if (m_axi_awready) aw_vld <= 1'b0;
               if (m_axi_wready)  w_vld  <= 1'b0;
               if ((!aw_vld || m_axi_awready) && (!w_vld || m_axi_wready)) begin
                  b_rdy <= 1'b1;
                  state <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (m_axi_bvalid) begin
                  if (m_axi_bresp != AXI_RESP_OKAY) err_r <= 1'b1;
                  pat   <= cur;
                  wcnt  <= wcnt + 16'd1;
                  cur   <= nxt;
                  cnt   <= interval;
                  b_rdy <= 1'b0;
                  state <= enable ? ST_WAIT : ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (!enable) begin
                  state <= ST_IDLE;
               end else if (cnt == '0) begin
                  aw_vld <= 1'b1;
                  w_vld  <= 1'b1;
                  state  <= ST_ISSUE;
               end else begin
                  cnt <= cnt - CNT_WIDTH'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign m_axi_awaddr  = GPIO_ADDR;
   assign m_axi_awvalid = aw_vld;
   assign m_axi_wdata   = cur;
   assign m_axi_wstrb   = '1;
   assign m_axi_wvalid  = w_vld;
   assign m_axi_bready  = b_rdy;
   assign pattern_out   = pat;
   assign write_count   = wcnt;
   assign err           = err_r;

endmodule

// File: tb/tb_gpio_pattern_sequencer.sv
// Randomized bench: AXI-lite slave model, closed-form pattern model feeding a
// scoreboard queue, and a negedge monitor that checks every write and response.
module tb_gpio_pattern_sequencer;
   import gpio_seq_pkg::*;

   localparam int CW = 24;

   logic          clk = 1'b0, resetn = 1'b0, enable = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic [31:0]   seed = '0;
   logic [CW-1:0] interval = '0;
   logic [11:0]   awaddr;
   logic          awvalid, wvalid, bready, err;
   logic          awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
   logic [31:0]   wdata, pattern_out;
   logic [3:0]    wstrb;
   logic [1:0]    bresp = 2'b00;
   logic [15:0]   write_count;

   gpio_pattern_sequencer #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .GPIO_ADDR(12'h000), .CNT_WIDTH(CW)) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .mode(mode), .seed(seed), .interval(interval),
      .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .pattern_out(pattern_out), .write_count(write_count), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   logic [31:0] exp_q[$];
   int ord = 0, err_at = -1;
   int exp_cnt = 0;
   logic exp_err = 1'b0, idle_exp = 1'b0;
   logic [1:0]  cur_m;
   logic [31:0] cur_s;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // k-th written pattern straight from the mode rules (k=0 is the seed)
   function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] s, input int k);
      logic [63:0] d;
      int r;
      case (m)
         MODE_CNT: return s + 32'(k);
         MODE_WALK: begin
            if (s == 0) begin
               if (k == 0) return 32'h0;
               d = {32'h1, 32'h1};
               r = (k - 1) % 32;
            end else begin
               d = {s, s};
               r = k % 32;
            end
            d = d << r;
            return d[63:32];
         end
         MODE_TOGGLE: return (k % 2 == 1) ? ~s : s;
         default: return s;
      endcase
   endfunction

   // slave model + monitor
   int ncyc = 0, tb_b = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
   logic aw_got = 0, w_got = 0, b_hs_prev = 0, pend = 0, after_b = 0;
   logic prev_aw = 0, prev_aw_pend = 0, prev_w_pend = 0, prev_aw_hs = 0, prev_w_hs = 0;
   logic [31:0] prev_wdata = '0, cur_exp = '0, exp_pat = '0;

   always @(negedge clk) begin
      logic aw_hs, w_hs, b_hs;
      ncyc++;
      if (!resetn) begin
         awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
         aw_got = 0; w_got = 0; b_hs_prev = 0; pend = 0; after_b = 0;
         prev_aw = 0; prev_aw_pend = 0; prev_w_pend = 0; prev_aw_hs = 0; prev_w_hs = 0;
         aw_cnt = 0; w_cnt = 0; b_cnt = 0;
         exp_cnt = 0; exp_err = 0; exp_pat = '0;
      end else begin
         if (awvalid && !prev_aw) begin
            case (ord)
               1: begin aw_dly = 0; w_dly = 6; b_dly = 1; end
               2: begin aw_dly = 6; w_dly = 0; b_dly = 1; end
               3: begin aw_dly = 2; w_dly = 2; b_dly = 1; end
               4: begin aw_dly = 5; w_dly = 0; b_dly = 0; end
               5: begin aw_dly = 0; w_dly = 0; b_dly = 8; end
               6: begin aw_dly = 0; w_dly = 0; b_dly = 0; end
               default: begin
                  aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
               end
            endcase
            if (after_b) chk("wait_gap", 32'(ncyc - tb_b), 32'(interval) + 32'd2);
         end
         awready = awvalid && (aw_cnt >= aw_dly);
         if (awvalid) aw_cnt++; else aw_cnt = 0;
         wready = wvalid && (w_cnt >= w_dly);
         if (wvalid) w_cnt++; else w_cnt = 0;
         if (b_hs_prev) begin
            bvalid = 0;
         end else if (aw_got && w_got && !bvalid) begin
            if (b_cnt >= b_dly) begin
               bvalid = 1;
               bresp = (exp_cnt == err_at) ? 2'b10 : 2'b00;
               b_cnt = 0;
            end else b_cnt++;
         end
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         b_hs  = bvalid && bready;

         if (pend) begin
            chk("pattern_out", pattern_out, exp_pat);
            chk("write_count", 32'(write_count), 32'(exp_cnt));
            chk("err", 32'(err), 32'(exp_err));
            pend = 0;
         end
         if (prev_aw_pend) chk("awvalid_hold", 32'(awvalid), 32'd1);
         if (prev_w_pend) begin
            chk("wvalid_hold", 32'(wvalid), 32'd1);
            chk("wdata_stable", wdata, prev_wdata);
         end
         if (prev_aw_hs) chk("awvalid_drop", 32'(awvalid), 32'd0);
         if (prev_w_hs)  chk("wvalid_drop", 32'(wvalid), 32'd0);
         if (idle_exp)   chk("no_aw_when_idle", 32'(awvalid), 32'd0);

         if (aw_hs) begin
            chk("awaddr", 32'(awaddr), 32'h0);
            if (aw_got) chk("one_outstanding_aw", 32'(aw_got), 32'd0);
            aw_got = 1;
         end
         if (w_hs) begin
            chk("wstrb", 32'(wstrb), 32'hF);
            if (exp_q.size() == 0) begin
               chk("unexpected_write", 32'(exp_q.size()), 32'd1);
            end else begin
               cur_exp = exp_q.pop_front();
               chk("wdata", wdata, cur_exp);
            end
            w_got = 1;
         end
         b_hs_prev = b_hs;
         if (b_hs) begin
            exp_pat = cur_exp;
            exp_cnt++;
            exp_err = exp_err | (bresp != 2'b00);
            pend = 1; after_b = enable; tb_b = ncyc;
            aw_got = 0; w_got = 0;
         end
         if (!enable) after_b = 0;
         prev_aw_pend = awvalid && !aw_hs;
         prev_w_pend  = wvalid && !w_hs;
         prev_aw_hs = aw_hs; prev_w_hs = w_hs;
         prev_wdata = wdata;
         prev_aw = awvalid;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push_exp(input int n);
      exp_q.delete();
      for (int k = 0; k < n + 2; k++) exp_q.push_back(model(cur_m, cur_s, k));
   endtask

   task automatic wait_wc(input int n);
      int t = 0;
      while (write_count != 16'(n) && t < 5000) begin tick(); t++; end
      if (t >= 5000) chk("timeout_write_count", 32'(write_count), 32'(n));
   endtask

   task automatic start(input logic [1:0] m, input logic [31:0] s, input int iv, input int o,
                        input int ea, input int n);
      mode = m; seed = s; interval = CW'(iv); ord = o; err_at = ea;
      cur_m = m; cur_s = s;
      push_exp(n);
      exp_cnt = 0; exp_err = 0; idle_exp = 0;
      enable = 1;
      tick();
      chk("restart_awvalid", 32'(awvalid), 32'd1);
      chk("restart_err", 32'(err), 32'd0);
      chk("restart_count", 32'(write_count), 32'd0);
   endtask

   task automatic finish(input int n);
      wait_wc(n);
      enable = 0;
      idle_exp = 1;
      repeat (4) tick();
      chk("end_count", 32'(write_count), 32'(n));
      chk("end_pattern", pattern_out, model(cur_m, cur_s, n - 1));
      chk("end_err", 32'(err), 32'(exp_err));
   endtask

   task automatic chk_reset_outputs();
      chk("rst_awvalid", 32'(awvalid), 32'd0);
      chk("rst_wvalid", 32'(wvalid), 32'd0);
      chk("rst_bready", 32'(bready), 32'd0);
      chk("rst_wdata", wdata, 32'd0);
      chk("rst_pattern_out", pattern_out, 32'd0);
      chk("rst_write_count", 32'(write_count), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
   endtask

   initial begin
      logic [31:0] s;
      int t;
      resetn = 0;
      repeat (3) tick();
      chk_reset_outputs();
      resetn = 1;
      tick();

      // counter mode, always-ready slave
      start(MODE_CNT, 32'h0000_00FE, 3, 6, -1, 3);
      finish(3);

      // walking one from zero, through the 0x8000_0000 -> 0x1 wrap
      start(MODE_WALK, 32'h0, $urandom_range(0, 2), 0, -1, 34);
      finish(34);

      // SLVERR on the second write; err must stick through later OKAYs
      start(MODE_TOGGLE, $urandom, 1, 0, 1, 4);
      finish(4);
      chk("err_sticky", 32'(err), 32'd1);

      // restart clears err; hold mode with random seeds and intervals
      start(MODE_HOLD, $urandom, $urandom_range(0, 3), 0, -1, 3);
      finish(3);
      start(MODE_CNT, 32'hFFFF_FFFE, 0, 0, -1, 4);
      finish(4);
      start(MODE_WALK, $urandom | 32'h1, 2, 0, -1, 5);
      finish(5);

      // handshake orderings: AW first, W first, simultaneous
      for (int o = 1; o <= 3; o++) begin
         start(MODE_CNT, $urandom, 0, o, -1, 1);
         finish(1);
      end

      // drop enable while AW is stalled in ISSUE
      s = $urandom;
      start(MODE_CNT, s, 0, 4, -1, 1);
      enable = 0;
      wait_wc(1);
      idle_exp = 1;
      repeat (10) tick();
      chk("dis_count", 32'(write_count), 32'd1);
      chk("dis_pattern", pattern_out, s);
      chk("dis_awvalid", 32'(awvalid), 32'd0);

      // synchronous reset while waiting for B, then restart from seed
      s = $urandom;
      start(MODE_WALK, s, 1, 5, -1, 2);
      t = 0;
      while (!bready && t < 50) begin tick(); t++; end
      chk("reached_resp", 32'(bready), 32'd1);
      resetn = 0;
      tick();
      chk_reset_outputs();
      push_exp(2);
      resetn = 1;
      finish(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
